// File: rtl/ibex_xif_result_buffer.sv
// ibex_xif_result_buffer: in-order FIFO of coprocessor results feeding register writeback,
// holding off writeback while a coprocessor exception awaits controller acknowledgement.
module ibex_xif_result_buffer #(
  parameter int unsigned X_ID_WIDTH = 4,
  parameter int unsigned RB_DEPTH   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  result_valid_i,
  output logic                  result_ready_o,
  input  logic [X_ID_WIDTH-1:0] result_id_i,
  input  logic [31:0]           result_data_i,
  input  logic [4:0]            result_rd_i,
  input  logic                  result_we_i,
  input  logic                  result_exc_i,
  input  logic [5:0]            result_exccode_i,
  output logic                  result_handshake_o,
  output logic [X_ID_WIDTH-1:0] result_id_o,
  input  logic                  rf_wb_ready_i,
  output logic                  rf_we_o,
  output logic [4:0]            rf_waddr_o,
  output logic [31:0]           rf_wdata_o,
  output logic                  xif_exception_o,
  output logic [5:0]            xif_exccode_o,
  input  logic                  exc_ack_i
);
  localparam int unsigned PW = $clog2(RB_DEPTH);
  localparam int unsigned CW = $clog2(RB_DEPTH + 1);
  typedef enum logic {RUN, EXC_WAIT} state_e;
  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [31:0]           data;
    logic [4:0]            rd;
    logic                  we;
    logic                  exc;
    logic [5:0]            exccode;
  } entry_t;
  entry_t        mem [RB_DEPTH];
  entry_t        head;
  state_e        state_q, state_d;
  logic [PW-1:0] rptr_q, wptr_q;
  logic [CW-1:0] cnt_q;
  logic [5:0]    exccode_q;
  logic          run, nonempty, push, pop, flush;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(RB_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign run                = (state_q == RUN);
  assign nonempty           = (cnt_q != '0);
  assign head               = mem[rptr_q];
  assign result_ready_o     = (run && cnt_q < CW'(RB_DEPTH)) || !run;
  assign result_handshake_o = rst_ni && result_valid_i && result_ready_o;
  assign result_id_o        = result_id_i;
  assign push               = result_handshake_o && run;
  assign pop                = run && nonempty && rf_wb_ready_i;
  // An excepting head flushes everything, including a result arriving alongside it.
  assign flush              = pop && head.exc;
  assign rf_we_o            = pop && head.we && !head.exc && (head.rd != 5'd0);
  assign rf_waddr_o         = nonempty ? head.rd : '0;
  assign rf_wdata_o         = nonempty ? head.data : '0;
  assign xif_exception_o    = !run;
  assign xif_exccode_o      = run ? '0 : exccode_q;
  always_comb begin
    state_d = state_q;
    state_d = run ? (flush ? EXC_WAIT : RUN) : (exc_ack_i ? RUN : EXC_WAIT);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RUN;
      rptr_q    <= '0;
      wptr_q    <= '0;
      cnt_q     <= '0;
      exccode_q <= '0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        rptr_q    <= '0;
        wptr_q    <= '0;
        cnt_q     <= '0;
        exccode_q <= head.exccode;
      end else if (run) begin
        if (push) wptr_q <= inc(wptr_q);
        if (pop) rptr_q <= inc(rptr_q);
        cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr_q] <= '{id: result_id_i, data: result_data_i, rd: result_rd_i,
                               we: result_we_i, exc: result_exc_i, exccode: result_exccode_i};
  end
endmodule

// File: doc/ibex_xif_result_buffer.md
IBEX_XIF_RESULT_BUFFER -- requirements
Module: ibex_xif_result_buffer

Interface
REQ-001 Parameter X_ID_WIDTH, default 4: width of X-interface instruction IDs.
REQ-002 Parameter RB_DEPTH, default 2: number of result entries buffered; legal values 2..4.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 result_valid_i  input  1  coprocessor offers a result.
REQ-006 result_ready_o  output  1  buffer accepts the offered result.
REQ-007 result_id_i  input  X_ID_WIDTH  ID of the offered result.
REQ-008 result_data_i  input  32  result value.
REQ-009 result_rd_i  input  5  destination register.
REQ-010 result_we_i  input  1  result writes rd.
REQ-011 result_exc_i  input  1  result carries a synchronous exception.
REQ-012 result_exccode_i  input  6  exception code.
REQ-013 result_handshake_o  output  1  result accepted this cycle; drives the issue-commit buffer.
REQ-014 result_id_o  output  X_ID_WIDTH  ID of the accepted result; drives the issue-commit buffer.
REQ-015 rf_wb_ready_i  input  1  core writeback port free this cycle.
REQ-016 rf_we_o  output  1  register-file write enable.
REQ-017 rf_waddr_o  output  5  register-file write address.
REQ-018 rf_wdata_o  output  32  register-file write data.
REQ-019 xif_exception_o  output  1  pending coprocessor exception to controller.
REQ-020 xif_exccode_o  output  6  code of the pending exception.
REQ-021 exc_ack_i  input  1  controller has taken the exception.

Function
REQ-022 Storage SHALL be an in-order circular FIFO of RB_DEPTH entries {id, data, rd, we, exc, exccode}, with read/write pointers wrapping modulo RB_DEPTH and an occupancy counter 0..RB_DEPTH.
REQ-023 result_ready_o SHALL be 1 when state is RUN and occupancy < RB_DEPTH, or when state is EXC_WAIT; it SHALL NOT depend combinationally on result_valid_i.
REQ-024 result_handshake_o SHALL equal result_valid_i & result_ready_o in the same cycle; result_id_o SHALL equal result_id_i combinationally.
REQ-025 In RUN, a handshake SHALL push the entry; the entry is visible at the head no earlier than the next cycle (no pass-through).
REQ-026 In RUN, the head entry SHALL pop when occupancy > 0 and rf_wb_ready_i = 1.
REQ-027 rf_we_o SHALL be 1 only on a pop of a head entry with we = 1, exc = 0 and rd != 0; rf_waddr_o/rf_wdata_o SHALL show the head rd/data and SHALL be 0 when occupancy = 0.
REQ-028 When full, simultaneous pop and offer: the pop SHALL occur and the offer SHALL be refused that cycle (ready is 0).
REQ-029 Simultaneous push and pop at 0 < occupancy < RB_DEPTH SHALL leave occupancy unchanged.
REQ-030 FSM states: RUN, EXC_WAIT.
REQ-031 RUN -> EXC_WAIT when the popped head has exc = 1; the exccode SHALL be registered and no register write SHALL occur for that entry.
REQ-032 In EXC_WAIT: xif_exception_o = 1 and xif_exccode_o = registered code; all buffered entries SHALL be discarded on entry; incoming results SHALL be accepted (handshake reported) and dropped; rf_we_o = 0.
REQ-033 EXC_WAIT -> RUN on exc_ack_i = 1; the buffer is empty on the first RUN cycle; exc_ack_i in RUN SHALL be ignored.
REQ-034 In RUN, xif_exception_o and xif_exccode_o SHALL be 0.

Reset
REQ-035 On rst_ni = 0, regardless of activity: state RUN, occupancy 0, pointers 0, registered exccode 0; result_ready_o = 1, all other outputs 0.
REQ-036 Reset asserted mid-operation SHALL discard all buffered results without generating a register write.

Verification
REQ-037 Single result id=3, rd=5, we=1, data=0xDEADBEEF, rf_wb_ready_i=1 -> handshake with id 3 same cycle; rf_we_o=1, waddr=5, wdata=0xDEADBEEF next cycle.
REQ-038 rf_wb_ready_i=0, three back-to-back results (RB_DEPTH=2) -> first two accepted, third stalled with ready=0; after rf_wb_ready_i=1, writes emerge in ID order.
REQ-039 Result rd=0, we=1 -> accepted and popped, rf_we_o stays 0.
REQ-040 Result exc=1, exccode=0x02 behind one buffered normal result -> normal write first, then xif_exception_o=1, exccode 0x02, held until exc_ack_i; subsequent offers accepted with handshake but never written.
REQ-041 Buffer full, rst_ni pulsed low -> outputs at reset values, no rf_we_o afterwards, occupancy 0.
REQ-042 Continuous traffic with rf_wb_ready_i=1 for 20 results -> pointer wrap-around, no loss or reorder, one write per cycle.
